sc_buttons_debouncer_jug1: RTL and testbench
============================================

Name: sc_buttons_debouncer_jug1

Overview:
Conditions player-1's three raw push-buttons (start, left, right) before they reach the player-1 control state machine. Each raw key is asynchronous, active-low and bouncy. Each is synchronized into the 50 MHz domain, debounced with a per-channel stability counter, and presented as a clean active-low level. A one-cycle press-event pulse is also produced per button. The level outputs drive the state machine's startButton/leftButton/rightButton inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles of stable differing input required before the output changes (20 ms at 50 MHz); legal range >= 2.
- CNT_WIDTH, 20, stability counter width; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.

Ports:
- SC_STATEMACHINE_JUG1_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINE_JUG1_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_BTNDEB_JUG1_startRaw_InLow  in  1  raw start key, asynchronous, active-low.
- SC_BTNDEB_JUG1_leftRaw_InLow  in  1  raw left key, asynchronous, active-low.
- SC_BTNDEB_JUG1_rightRaw_InLow  in  1  raw right key, asynchronous, active-low.
- SC_BTNDEB_JUG1_start_OutLow  out  1  debounced start level, active-low.
- SC_BTNDEB_JUG1_left_OutLow  out  1  debounced left level, active-low.
- SC_BTNDEB_JUG1_right_OutLow  out  1  debounced right level, active-low.
- SC_BTNDEB_JUG1_pressPulse_Out  out  3  one-cycle high pulse on debounced press; bit0 start, bit1 left, bit2 right.

Behaviour:
- Reset: SC_STATEMACHINE_JUG1_RESET_InHigh is asynchronous, active-high; clock is SC_STATEMACHINE_JUG1_CLOCK_50. While reset is asserted:
  - sync stages = 1
  - all debounced outputs = 1 (released)
  - pressPulse = 3'b000
  - counters = 0
- Channels are fully independent. Identical logic runs per channel.
- Synchronizer: two flops, sync1 <= raw and sync2 <= sync1. sync2 is the only value used downstream.
- Counter rule, evaluated at each clock edge, in priority order:
  - sync2 == out: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: out <= sync2, cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: a clean raw step sampled at edge k produces an output change at edge k+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=4, that is edge k+5.
  - Press and release use the same latency.
- Glitch rejection: any reversion of sync2 to equal out before the count completes clears cnt. Pulses shorter than DEBOUNCE_CYCLES cycles never reach the output.
- pressPulse[i]:
  - Registered; high for exactly one cycle, on the same edge that out[i] goes 1->0.
  - Release (0->1) produces no pulse.
- Simultaneous presses on several channels are handled independently. Multiple pressPulse bits may be high in the same cycle.
- Reset mid-count: all counters are cleared and all outputs forced to released. Any pending transition is discarded, and no pulse is emitted on reset release.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- No combinational path from raw inputs to outputs.

Decomposition:
- Shared package holds:
  - button index constants BTN_START=0, BTN_LEFT=1, BTN_RIGHT=2
  - BTN_RELEASED=1'b1 and BTN_PRESSED=1'b0
  - default DEBOUNCE_CYCLES constant
- One sub-module, sc_debounce_channel: synchronizer, counter, output and pulse registers for a single key. It is instantiated three times, with DEBOUNCE_CYCLES/CNT_WIDTH passed through.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, CNT_WIDTH=3.)
1. Reset: hold reset with all raw=0 → outputs=1 and pulse=000. Release reset with raw=1 for 10 cycles → outputs stay 1, no pulse.
2. Clean press: left raw 1->0 sampled at edge k → left_OutLow=0 at edge k+5, pressPulse=3'b010 for that cycle only. Raw 0->1 later → left_OutLow=1 five edges after sampling, no pulse.
3. Glitch: start raw low for 3 cycles, then high → start_OutLow stays 1 throughout, pressPulse stays 000.
4. Bounce train: right raw toggles 0,1,0,1,0, then holds 0 → right_OutLow=0 exactly 5 edges after the final 1->0 sample, one pulse 3'b100.
5. Simultaneous: start and right both go low at the same edge → both outputs fall on the same edge, pressPulse=3'b101 for one cycle. Left stays 1.
6. Reset mid-count: left raw low, reset asserted after 2 counted cycles and released with raw still low → output stays 1 during reset. Output falls 1+4 edges after the first post-reset sampling edge (synchronizer refill included), one pulse.

Source files
------------

// File: rtl/sc_buttons_debouncer_jug1_pkg.sv
// Shared constants for the player-1 button debouncer.
// Button indices select bits of the press-pulse vector. The level encoding is
// active-low, so "released" is 1. The default debounce length is 20 ms at 50 MHz.
package sc_buttons_debouncer_jug1_pkg;

  localparam int NUM_BTN   = 3;
  localparam int BTN_START = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;

  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED  = 1'b0;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_WIDTH_DEF       = 20;

endpackage

// File: rtl/sc_buttons_debouncer_jug1_if.sv
// Button bundle between the raw key pads, the debouncer, and the player-1
// state machine.
//   *Raw_InLow      raw asynchronous active-low keys
//   *_OutLow        debounced active-low levels
//   pressPulse_Out  one-cycle press events: bit0 start, bit1 left, bit2 right
// master: the key side, which drives the raw keys and observes the results.
// slave : the debouncer.
interface sc_buttons_debouncer_jug1_if;

  logic       SC_BTNDEB_JUG1_startRaw_InLow;
  logic       SC_BTNDEB_JUG1_leftRaw_InLow;
  logic       SC_BTNDEB_JUG1_rightRaw_InLow;
  logic       SC_BTNDEB_JUG1_start_OutLow;
  logic       SC_BTNDEB_JUG1_left_OutLow;
  logic       SC_BTNDEB_JUG1_right_OutLow;
  logic [2:0] SC_BTNDEB_JUG1_pressPulse_Out;

  modport master (
    output SC_BTNDEB_JUG1_startRaw_InLow, SC_BTNDEB_JUG1_leftRaw_InLow,
           SC_BTNDEB_JUG1_rightRaw_InLow,
    input  SC_BTNDEB_JUG1_start_OutLow, SC_BTNDEB_JUG1_left_OutLow,
           SC_BTNDEB_JUG1_right_OutLow, SC_BTNDEB_JUG1_pressPulse_Out
  );

  modport slave (
    input  SC_BTNDEB_JUG1_startRaw_InLow, SC_BTNDEB_JUG1_leftRaw_InLow,
           SC_BTNDEB_JUG1_rightRaw_InLow,
    output SC_BTNDEB_JUG1_start_OutLow, SC_BTNDEB_JUG1_left_OutLow,
           SC_BTNDEB_JUG1_right_OutLow, SC_BTNDEB_JUG1_pressPulse_Out
  );

endinterface

// File: rtl/sc_buttons_debouncer_jug1_debounce_channel.sv
// sc_debounce_channel: conditions a single raw key.
// The key passes through a 2-flop synchronizer and then a stability counter.
// The output takes the synchronized value only after that value has differed
// from the output for DEBOUNCE_CYCLES consecutive edges.
//   i_clk, i_rst  clock and async active-high reset
//   i_raw_n       raw key, asynchronous, active-low
//   o_lvl_n       debounced level, active-low
//   o_press       one-cycle pulse on the edge where o_lvl_n falls
module sc_debounce_channel
  import sc_buttons_debouncer_jug1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw_n,
  output logic o_lvl_n,
  output logic o_press
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1, r_sync2, r_lvl, r_press;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_differs, w_done;

  assign w_differs = (r_sync2 != r_lvl);
  assign w_done    = w_differs && (r_cnt == CNT_LAST);

  // Any cycle where the synchronized key matches the output clears the count.
  // A glitch shorter than DEBOUNCE_CYCLES therefore never commits. The count
  // stops at CNT_LAST, so it cannot wrap around.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= BTN_RELEASED;
      r_sync2 <= BTN_RELEASED;
      r_lvl   <= BTN_RELEASED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_raw_n;
      r_sync2 <= r_sync1;
      r_press <= w_done && (r_sync2 == BTN_PRESSED);
      if (!w_differs || w_done) r_cnt <= '0;
      else                      r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_done) r_lvl <= r_sync2;
    end
  end

  assign o_lvl_n = r_lvl;
  assign o_press = r_press;

endmodule

// File: rtl/sc_buttons_debouncer_jug1.sv
// Player-1 button conditioner: start, left and right keys, with one
// independent debounce channel per key.
//   SC_STATEMACHINE_JUG1_CLOCK_50     50 MHz clock
//   SC_STATEMACHINE_JUG1_RESET_InHigh async active-high reset
//   bif (slave)                       raw keys in; debounced levels and press pulses out
// All outputs are registered. No combinational path runs from a raw key to an output.
module sc_buttons_debouncer_jug1
  import sc_buttons_debouncer_jug1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                        SC_STATEMACHINE_JUG1_CLOCK_50,
  input  logic                        SC_STATEMACHINE_JUG1_RESET_InHigh,
  sc_buttons_debouncer_jug1_if.slave  bif
);

  logic [NUM_BTN-1:0] w_raw_n, w_lvl_n, w_press;

  assign w_raw_n[BTN_START] = bif.SC_BTNDEB_JUG1_startRaw_InLow;
  assign w_raw_n[BTN_LEFT]  = bif.SC_BTNDEB_JUG1_leftRaw_InLow;
  assign w_raw_n[BTN_RIGHT] = bif.SC_BTNDEB_JUG1_rightRaw_InLow;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    sc_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_ch (
      .i_clk   (SC_STATEMACHINE_JUG1_CLOCK_50),
      .i_rst   (SC_STATEMACHINE_JUG1_RESET_InHigh),
      .i_raw_n (w_raw_n[g]),
      .o_lvl_n (w_lvl_n[g]),
      .o_press (w_press[g])
    );
  end

  assign bif.SC_BTNDEB_JUG1_start_OutLow   = w_lvl_n[BTN_START];
  assign bif.SC_BTNDEB_JUG1_left_OutLow    = w_lvl_n[BTN_LEFT];
  assign bif.SC_BTNDEB_JUG1_right_OutLow   = w_lvl_n[BTN_RIGHT];
  assign bif.SC_BTNDEB_JUG1_pressPulse_Out = w_press;

endmodule

// File: tb/tb_sc_buttons_debouncer_jug1.sv
// Bench for sc_buttons_debouncer_jug1 with DEBOUNCE_CYCLES=4 and CNT_WIDTH=3.
// A window model predicts every cycle: a level flips once the 4 samples taken
// 2..5 edges earlier all disagree with it, and reset refills the history with
// "released". Each prediction is queued when the stimulus is driven and popped
// after the edge. The table and the hand sequences add hand-derived checks on top.
module tb_sc_buttons_debouncer_jug1;

  localparam int D  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [2:0] lvl;
    logic [2:0] pulse;
  } exp_t;

  typedef struct {
    logic [2:0] raw;      // {right,left,start}, active-low
    int         hold;
    logic [2:0] exp_lvl;
    logic [2:0] exp_pul;  // channels that must pulse exactly once
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  sc_buttons_debouncer_jug1_if bif ();

  sc_buttons_debouncer_jug1 #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .SC_STATEMACHINE_JUG1_CLOCK_50     (clk),
    .SC_STATEMACHINE_JUG1_RESET_InHigh (rst),
    .bif                               (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t       sbq[$];
  logic [D:0] m_hist[3];
  logic [2:0] m_out, m_pulse;
  logic [2:0] cur_lvl, cur_pulse;
  int         pcnt[3];

  task automatic check(input string nm, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic r);
    for (int c = 0; c < 3; c++) begin
      m_pulse[c] = 1'b0;
      if (r) begin
        m_hist[c] = '1;
        m_out[c]  = 1'b1;
      end else begin
        if (m_hist[c][D:1] == {D{~m_out[c]}}) begin
          m_out[c]   = ~m_out[c];
          m_pulse[c] = ~m_out[c];
        end
        m_hist[c] = {m_hist[c][D-1:0], raw[c]};
      end
    end
  endtask

  task automatic cyc(input logic [2:0] raw, input logic r);
    exp_t e;
    bif.SC_BTNDEB_JUG1_startRaw_InLow = raw[0];
    bif.SC_BTNDEB_JUG1_leftRaw_InLow  = raw[1];
    bif.SC_BTNDEB_JUG1_rightRaw_InLow = raw[2];
    rst = r;
    model_edge(raw, r);
    e.lvl = m_out; e.pulse = m_pulse;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cur_lvl   = {bif.SC_BTNDEB_JUG1_right_OutLow, bif.SC_BTNDEB_JUG1_left_OutLow,
                 bif.SC_BTNDEB_JUG1_start_OutLow};
    cur_pulse = bif.SC_BTNDEB_JUG1_pressPulse_Out;
    e = sbq.pop_front();
    check("sb_lvl", cur_lvl, e.lvl);
    check("sb_pulse", cur_pulse, e.pulse);
    for (int c = 0; c < 3; c++) if (cur_pulse[c]) pcnt[c]++;
  endtask

  // Holds raw for n edges; a press must fall exactly on the last of them.
  task automatic press_exact(input string nm, input logic [2:0] raw, input int n,
                             input logic [2:0] lvl_before, input logic [2:0] lvl_after,
                             input logic [2:0] pul_after);
    for (int i = 0; i < n; i++) begin
      cyc(raw, 1'b0);
      if (i < n - 1) begin
        check({nm, "_wait_lvl"}, cur_lvl, lvl_before);
        check({nm, "_wait_pul"}, cur_pulse, 3'b000);
      end else begin
        check({nm, "_edge_lvl"}, cur_lvl, lvl_after);
        check({nm, "_edge_pul"}, cur_pulse, pul_after);
      end
    end
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{raw: 3'b111, hold: 10, exp_lvl: 3'b111, exp_pul: 3'b000};
    vt[1] = '{raw: 3'b110, hold: 3,  exp_lvl: 3'b111, exp_pul: 3'b000};
    vt[2] = '{raw: 3'b111, hold: 8,  exp_lvl: 3'b111, exp_pul: 3'b000};
    vt[3] = '{raw: 3'b101, hold: 8,  exp_lvl: 3'b101, exp_pul: 3'b010};
    vt[4] = '{raw: 3'b111, hold: 8,  exp_lvl: 3'b111, exp_pul: 3'b000};
    vt[5] = '{raw: 3'b010, hold: 8,  exp_lvl: 3'b010, exp_pul: 3'b101};
    vt[6] = '{raw: 3'b111, hold: 8,  exp_lvl: 3'b111, exp_pul: 3'b000};

    for (int c = 0; c < 3; c++) m_hist[c] = '1;
    m_out = 3'b111; m_pulse = 3'b000;

    // Hold reset with every key pressed: everything must read released.
    for (int i = 0; i < 4; i++) begin
      cyc(3'b000, 1'b1);
      check("rst_lvl", cur_lvl, 3'b111);
      check("rst_pul", cur_pulse, 3'b000);
    end

    for (int v = 0; v < 7; v++) begin
      logic [2:0] seen, multi;
      for (int c = 0; c < 3; c++) pcnt[c] = 0;
      for (int i = 0; i < vt[v].hold; i++) cyc(vt[v].raw, 1'b0);
      for (int c = 0; c < 3; c++) begin
        seen[c]  = (pcnt[c] != 0);
        multi[c] = (pcnt[c] > 1);
      end
      check($sformatf("tbl%0d_lvl", v), cur_lvl, vt[v].exp_lvl);
      check($sformatf("tbl%0d_pul", v), seen, vt[v].exp_pul);
      check($sformatf("tbl%0d_multi", v), multi, 3'b000);
    end

    // Clean left press: the level falls 5 edges after sampling, with one pulse.
    press_exact("left_press", 3'b101, 6, 3'b111, 3'b101, 3'b010);
    cyc(3'b101, 1'b0);
    check("left_pulse_once", cur_pulse, 3'b000);
    press_exact("left_release", 3'b111, 6, 3'b101, 3'b111, 3'b000);

    // Right bounce train 0,1,0,1, then the final fall and hold.
    cyc(3'b011, 1'b0); cyc(3'b111, 1'b0); cyc(3'b011, 1'b0); cyc(3'b111, 1'b0);
    check("bounce_lvl", cur_lvl, 3'b111);
    press_exact("bounce", 3'b011, 6, 3'b111, 3'b011, 3'b100);
    for (int i = 0; i < 8; i++) cyc(3'b111, 1'b0);
    check("bounce_rel", cur_lvl, 3'b111);

    // Left press interrupted by reset after two counted edges.
    for (int i = 0; i < 4; i++) cyc(3'b101, 1'b0);
    check("midrst_pre", cur_lvl, 3'b111);
    for (int i = 0; i < 3; i++) begin
      cyc(3'b101, 1'b1);
      check("midrst_lvl", cur_lvl, 3'b111);
      check("midrst_pul", cur_pulse, 3'b000);
    end
    press_exact("midrst_post", 3'b101, 6, 3'b111, 3'b101, 3'b010);
    for (int i = 0; i < 8; i++) cyc(3'b111, 1'b0);
    check("midrst_rel", cur_lvl, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
